alu_op_sequencer: RTL and testbench

//  Multi-cycle front end that drives the 4-bit-control MIPS ALU. Accepts an instruction
//  (opcode, funct, two operands) over a valid/ready handshake. Decodes it to the ALU control

---
 rtl/alu_op_sequencer_if.sv | 28 ++
 rtl/alu_op_sequencer.sv | 158 +++++++++++++++
 tb/tb_alu_op_sequencer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// Request/response bus between instruction decode and the ALU op sequencer.
// The sequencer connects through the slave modport and the decode/consumer side through master.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [5:0]       req_opcode;
    logic [5:0]       req_funct;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_data;
    logic             resp_zero;
    logic             resp_taken;
    logic             resp_err;

    modport slave (
        input  req_valid, req_opcode, req_funct, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_data, resp_zero, resp_taken, resp_err
    );

    modport master (
        output req_valid, req_opcode, req_funct, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_zero, resp_taken, resp_err
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Multi-cycle front end for the 4-bit-control MIPS ALU: decode, one-cycle issue, registered response.
// Optional feature: define ALU_SEQ_BNE_EN to accept bne (opcode 000101) with taken = !zero.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  IDLE  | req_ready high, waiting for a request
//  ISSUE | decoded op and operands on the ALU for one cycle
//  RESP  | response held on the bus until resp_ready
module alu_op_sequencer #(
    parameter int          WIDTH    = 32,
    parameter logic [3:0]  NOP_CTRL = 4'b1111
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_seq_if.slave         bus,
    output logic [3:0]       alu_ctrl,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    typedef enum logic [1:0] {BR_NONE, BR_EQ, BR_NE} br_t;

    state_t           state_q, state_nxt;
    br_t              br_q, br_nxt;
    logic [3:0]       ctrl_nxt;
    logic [WIDTH-1:0] in1_nxt, in2_nxt;
    logic             req_ready_q, req_ready_nxt;
    logic             resp_valid_q, resp_valid_nxt;
    logic [WIDTH-1:0] resp_data_q, resp_data_nxt;
    logic             resp_zero_q, resp_zero_nxt;
    logic             resp_taken_q, resp_taken_nxt;
    logic             resp_err_q, resp_err_nxt;

    logic             dec_legal;
    logic [3:0]       dec_ctrl;
    br_t              dec_br;

    always_comb begin
        dec_legal = 1'b1;
        dec_ctrl  = NOP_CTRL;
        dec_br    = BR_NONE;
        case (bus.req_opcode)
            6'b000000: begin
                case (bus.req_funct)
                    6'b100000: dec_ctrl = 4'b0010;
                    6'b100010: dec_ctrl = 4'b0110;
                    6'b100100: dec_ctrl = 4'b0000;
                    6'b100101: dec_ctrl = 4'b0001;
                    6'b101010: dec_ctrl = 4'b0111;
                    default:   dec_legal = 1'b0;
                endcase
            end
            6'b100011, 6'b101011, 6'b001000: dec_ctrl = 4'b0010;
            6'b000100: begin
                dec_ctrl = 4'b0110;
                dec_br   = BR_EQ;
            end
`ifdef ALU_SEQ_BNE_EN
            6'b000101: begin
                dec_ctrl = 4'b0110;
                dec_br   = BR_NE;
            end
`endif
            6'b001100: dec_ctrl = 4'b0000;
            6'b001101: dec_ctrl = 4'b0001;
            6'b001010: dec_ctrl = 4'b0111;
            default:   dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt      = state_q;
        br_nxt         = br_q;
        ctrl_nxt       = NOP_CTRL;
        in1_nxt        = alu_in1;
        in2_nxt        = alu_in2;
        resp_valid_nxt = resp_valid_q;
        resp_data_nxt  = resp_data_q;
        resp_zero_nxt  = resp_zero_q;
        resp_taken_nxt = resp_taken_q;
        resp_err_nxt   = resp_err_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    if (dec_legal) begin
                        state_nxt = ISSUE;
                        br_nxt    = dec_br;
                        ctrl_nxt  = dec_ctrl;
                        in1_nxt   = bus.req_a;
                        in2_nxt   = bus.req_b;
                    end else begin
                        // Illegal ops skip the ALU entirely and answer with an error.
                        state_nxt      = RESP;
                        br_nxt         = BR_NONE;
                        resp_valid_nxt = 1'b1;
                        resp_data_nxt  = '0;
                        resp_zero_nxt  = 1'b0;
                        resp_taken_nxt = 1'b0;
                        resp_err_nxt   = 1'b1;
                    end
                end
            end
            ISSUE: begin
                state_nxt      = RESP;
                resp_valid_nxt = 1'b1;
                resp_data_nxt  = alu_result;
                resp_zero_nxt  = alu_zero;
                resp_taken_nxt = ((br_q == BR_EQ) && alu_zero) || ((br_q == BR_NE) && !alu_zero);
                resp_err_nxt   = 1'b0;
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_nxt      = IDLE;
                    resp_valid_nxt = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
        req_ready_nxt = (state_nxt == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            br_q         <= BR_NONE;
            alu_ctrl     <= NOP_CTRL;
            alu_in1      <= '0;
            alu_in2      <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_zero_q  <= 1'b0;
            resp_taken_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            br_q         <= br_nxt;
            alu_ctrl     <= ctrl_nxt;
            alu_in1      <= in1_nxt;
            alu_in2      <= in2_nxt;
            req_ready_q  <= req_ready_nxt;
            resp_valid_q <= resp_valid_nxt;
            resp_data_q  <= resp_data_nxt;
            resp_zero_q  <= resp_zero_nxt;
            resp_taken_q <= resp_taken_nxt;
            resp_err_q   <= resp_err_nxt;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_zero  = resp_zero_q;
    assign bus.resp_taken = resp_taken_q;
    assign bus.resp_err   = resp_err_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: table of ops with hand-computed results through a small ALU model,
// checked via an expectation queue, plus reset and reset-during-issue sequences.
module tb_alu_op_sequencer;
    localparam int W = 32;

    typedef struct {
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic [31:0] data;
        logic        zero;
        logic        taken;
        logic        err;
        int          hold;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   alu_ctrl;
    logic [W-1:0] alu_in1, alu_in2, alu_result;
    logic         alu_zero;

    int checks = 0;
    int errors = 0;

    vec_t vecs[$];
    vec_t sb[$];

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_op_sequencer #(.WIDTH(W), .NOP_CTRL(4'b1111)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .alu_ctrl   (alu_ctrl),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_result (alu_result),
        .alu_zero   (alu_zero)
    );

    always #5 clk = ~clk;

    // Behavioural ALU the sequencer drives; NOP and unknown codes return 0.
    always_comb begin
        alu_result = '0;
        case (alu_ctrl)
            4'b0000: alu_result = alu_in1 & alu_in2;
            4'b0001: alu_result = alu_in1 | alu_in2;
            4'b0010: alu_result = alu_in1 + alu_in2;
            4'b0110: alu_result = alu_in1 - alu_in2;
            4'b0111: alu_result = (alu_in1 < alu_in2) ? 32'd1 : 32'd0;
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v);
        vec_t e;
        int   lat;
        int   k;
        bus.req_opcode = v.opcode;
        bus.req_funct  = v.funct;
        bus.req_a      = v.a;
        bus.req_b      = v.b;
        bus.req_valid  = 1'b1;
        bus.resp_ready = 1'b0;
        k = 0;
        while (!bus.req_ready && k < 8) begin
            @(negedge clk);
            k++;
        end
        chk("req_ready_before_accept", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk);
        sb.push_back(v);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("alu_ctrl_issue", {28'd0, alu_ctrl}, {28'd0, v.ctrl});
        chk("req_ready_busy", {31'd0, bus.req_ready}, 32'd0);
        if (!v.err) begin
            chk("alu_in1_issue", alu_in1, v.a);
            chk("alu_in2_issue", alu_in2, v.b);
        end
        lat = 1;
        while (!bus.resp_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, v.err ? 32'd1 : 32'd2);
        chk("alu_ctrl_resp", {28'd0, alu_ctrl}, 32'hF);
        for (int i = 0; i < v.hold; i++) begin
            chk("hold_valid", {31'd0, bus.resp_valid}, 32'd1);
            chk("hold_data", bus.resp_data, v.data);
            chk("hold_req_ready", {31'd0, bus.req_ready}, 32'd0);
            @(negedge clk);
        end
        bus.resp_ready = 1'b1;
        e = sb.pop_front();
        chk("resp_valid", {31'd0, bus.resp_valid}, 32'd1);
        chk("resp_data", bus.resp_data, e.data);
        chk("resp_zero", {31'd0, bus.resp_zero}, {31'd0, e.zero});
        chk("resp_taken", {31'd0, bus.resp_taken}, {31'd0, e.taken});
        chk("resp_err", {31'd0, bus.resp_err}, {31'd0, e.err});
        @(posedge clk);
        @(negedge clk);
        bus.resp_ready = 1'b0;
        chk("valid_after_ack", {31'd0, bus.resp_valid}, 32'd0);
        chk("ready_after_ack", {31'd0, bus.req_ready}, 32'd1);
    endtask

    initial begin
        vecs.push_back('{6'h00, 6'h20, 32'hFFFF_FFFF, 32'd1, 4'b0010, 32'd0, 1'b1, 1'b0, 1'b0, 0});
        vecs.push_back('{6'h00, 6'h22, 32'd10, 32'd3, 4'b0110, 32'd7, 1'b0, 1'b0, 1'b0, 0});
        vecs.push_back('{6'h00, 6'h22, 32'd0, 32'd1, 4'b0110, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{6'h00, 6'h24, 32'hF0F0, 32'hFF00, 4'b0000, 32'hF000, 1'b0, 1'b0, 1'b0, 0});
        vecs.push_back('{6'h00, 6'h25, 32'hF0F0, 32'h0F0F, 4'b0001, 32'hFFFF, 1'b0, 1'b0, 1'b0, 0});
        vecs.push_back('{6'h00, 6'h2A, 32'd3, 32'd7, 4'b0111, 32'd1, 1'b0, 1'b0, 1'b0, 4});
        vecs.push_back('{6'h00, 6'h2A, 32'hFFFF_FFFF, 32'd3, 4'b0111, 32'd0, 1'b1, 1'b0, 1'b0, 0});
        vecs.push_back('{6'h23, 6'h00, 32'd100, 32'd4, 4'b0010, 32'd104, 1'b0, 1'b0, 1'b0, 0});
        vecs.push_back('{6'h2B, 6'h3F, 32'd8, 32'd8, 4'b0010, 32'd16, 1'b0, 1'b0, 1'b0, 0});
        vecs.push_back('{6'h08, 6'h00, 32'd5, 32'hFFFF_FFFB, 4'b0010, 32'd0, 1'b1, 1'b0, 1'b0, 0});
        vecs.push_back('{6'h04, 6'h00, 32'h1234, 32'h1234, 4'b0110, 32'd0, 1'b1, 1'b1, 1'b0, 0});
        vecs.push_back('{6'h04, 6'h00, 32'd5, 32'd3, 4'b0110, 32'd2, 1'b0, 1'b0, 1'b0, 0});
        vecs.push_back('{6'h0C, 6'h00, 32'h00FF, 32'h0F0F, 4'b0000, 32'h000F, 1'b0, 1'b0, 1'b0, 0});
        vecs.push_back('{6'h0D, 6'h00, 32'h1000, 32'h0001, 4'b0001, 32'h1001, 1'b0, 1'b0, 1'b0, 0});
        vecs.push_back('{6'h0A, 6'h00, 32'd2, 32'd9, 4'b0111, 32'd1, 1'b0, 1'b0, 1'b0, 0});
        vecs.push_back('{6'h3F, 6'h20, 32'd1, 32'd1, 4'b1111, 32'd0, 1'b0, 1'b0, 1'b1, 2});
        vecs.push_back('{6'h00, 6'h27, 32'd1, 32'd1, 4'b1111, 32'd0, 1'b0, 1'b0, 1'b1, 0});
`ifdef ALU_SEQ_BNE_EN
        vecs.push_back('{6'h05, 6'h00, 32'd1, 32'd2, 4'b0110, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 0});
        vecs.push_back('{6'h05, 6'h00, 32'd4, 32'd4, 4'b0110, 32'd0, 1'b1, 1'b0, 1'b0, 0});
`else
        vecs.push_back('{6'h05, 6'h00, 32'd1, 32'd2, 4'b1111, 32'd0, 1'b0, 1'b0, 1'b1, 0});
`endif

        // Reset held for two cycles while a request is already presented.
        rst_n          = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_opcode = 6'h00;
        bus.req_funct  = 6'h20;
        bus.req_a      = 32'd1;
        bus.req_b      = 32'd1;
        bus.resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rst_alu_ctrl", {28'd0, alu_ctrl}, 32'hF);
        chk("rst_alu_in1", alu_in1, 32'd0);
        chk("rst_resp_data", bus.resp_data, 32'd0);
        rst_n         = 1'b1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("ready_after_release", {31'd0, bus.req_ready}, 32'd1);

        foreach (vecs[i]) run_op(vecs[i]);

        // Reset landing while the op is in ISSUE abandons it.
        bus.req_opcode = 6'h00;
        bus.req_funct  = 6'h20;
        bus.req_a      = 32'd7;
        bus.req_b      = 32'd9;
        bus.req_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("pre_rst_issue_ctrl", {28'd0, alu_ctrl}, 32'h2);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_ctrl", {28'd0, alu_ctrl}, 32'hF);
        chk("mid_rst_in1", alu_in1, 32'd0);
        chk("mid_rst_in2", alu_in2, 32'd0);
        chk("mid_rst_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("mid_rst_data", bus.resp_data, 32'd0);
        chk("mid_rst_ready", {31'd0, bus.req_ready}, 32'd0);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_no_resp", {31'd0, bus.resp_valid}, 32'd0);
        end
        chk("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("sb_empty", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
